// File: rtl/alu_logic_pkg.sv
// Shared opcode and FSM encodings for the logic-unit arbiter and its datapath slice.
package alu_logic_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational WIDTH-bit bitwise operation select (no carry chain).
module logic_op_unit
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves y unassigned (avoids an inferred latch).
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_NOT:  y = ~a;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic slice among N_REQ requesters.
// Optional RSP_ZERO flag output is built when ARB_ZERO_FLAG_EN is defined.
module logic_unit_arbiter
  import alu_logic_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [3*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
`ifdef ARB_ZERO_FLAG_EN
  output logic                   rsp_zero,
`endif
  output logic                   busy
);

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  next_ptr;
  logic             grant_found;
  logic             accept;
  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic [2:0]       op_arr [N_REQ];
  logic [WIDTH-1:0] op_y;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      a_arr[i]  = req_a[i*WIDTH +: WIDTH];
      b_arr[i]  = req_b[i*WIDTH +: WIDTH];
      op_arr[i] = req_op[3*i +: 3];
    end
  end

  // Scan from rr_ptr upward with wrap; the first valid index wins.
  always_comb begin
    int sum;
    grant_found = 1'b0;
    grant_id    = '0;
    sum         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      if (!grant_found && req_valid[ID_W'(sum)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(sum);
      end
    end
  end

  assign accept    = !rst && grant_found && ((state == ST_IDLE) || rsp_ready);
  assign req_ready = accept ? (N_REQ'(1) << grant_id) : '0;
  assign next_ptr  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy      = (state == ST_RESP);

  logic_op_unit #(.WIDTH(WIDTH)) u_op (
    .a  (a_arr[grant_id]),
    .b  (b_arr[grant_id]),
    .op (op_arr[grant_id]),
    .y  (op_y)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
`ifdef ARB_ZERO_FLAG_EN
      rsp_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= op_y;
            rsp_id    <= grant_id;
            rr_ptr    <= next_ptr;
`ifdef ARB_ZERO_FLAG_EN
            rsp_zero  <= (op_y == '0);
`endif
          end
        end
        ST_RESP: begin
          if (accept) begin
            // Retire and accept in the same cycle keeps one result per clock.
            rsp_data  <= op_y;
            rsp_id    <= grant_id;
            rr_ptr    <= next_ptr;
`ifdef ARB_ZERO_FLAG_EN
            rsp_zero  <= (op_y == '0);
`endif
          end else if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
